id_stage_pipelined: RTL and testbench

//  Parametrised decode stage: decodes the IF/ID instruction, reads the register file and

---
 rtl/rv32_pkg.sv | 57 +++++
 rtl/control_unit.sv | 38 +++
 rtl/immediate_extend.sv | 24 ++
 rtl/regfile_bypass.sv | 28 ++
 rtl/id_stage_pipelined.sv | 101 ++++++++++
 tb/tb_id_stage_pipelined.sv | 170 +++++++++++++++++
 6 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32IM decode definitions: opcodes, ALU op codes, ex_ctrl bit positions
// and immediate formats, used by the decode stage and its helpers.
package rv32_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ex_ctrl = {mux1,mux2,mux3,reg_wr,mem_wr,mem_rd,branch,jump,jal_sel}
  localparam int CTRL_W    = 9;
  localparam int C_JAL_SEL = 0;
  localparam int C_JUMP    = 1;
  localparam int C_BRANCH  = 2;
  localparam int C_MEM_RD  = 3;
  localparam int C_MEM_WR  = 4;
  localparam int C_REG_WR  = 5;
  localparam int C_MUX3    = 6;  // writeback from memory
  localparam int C_MUX2    = 7;  // ALU B = immediate
  localparam int C_MUX1    = 8;  // ALU A = pc

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  // M-extension ops occupy 16..23 as {2'b10, funct3}

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  function automatic logic [4:0] alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/control_unit.sv
// Opcode decoder: control bits, ALU op and immediate format. Unknown opcodes
// produce all-zero control so they have no side effects.
module control_unit
  import rv32_pkg::*;
(
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              alt,   // instr[30]
  input  logic              mext,  // instr[25]
  output logic [CTRL_W-1:0] ctrl,
  output logic [4:0]        alu_op,
  output logic [2:0]        imm_sel
);
  always_comb begin
    ctrl    = '0;
    alu_op  = ALU_ADD;
    imm_sel = IMM_I;
    case (opcode)
      OPC_LUI:    begin ctrl[C_MUX2] = 1'b1; ctrl[C_REG_WR] = 1'b1; alu_op = ALU_PASSB; imm_sel = IMM_U; end
      OPC_AUIPC:  begin ctrl[C_MUX1] = 1'b1; ctrl[C_MUX2] = 1'b1; ctrl[C_REG_WR] = 1'b1; imm_sel = IMM_U; end
      OPC_JAL:    begin ctrl[C_REG_WR] = 1'b1; ctrl[C_JUMP] = 1'b1; ctrl[C_JAL_SEL] = 1'b1; imm_sel = IMM_J; end
      OPC_JALR:   begin ctrl[C_MUX2] = 1'b1; ctrl[C_REG_WR] = 1'b1; ctrl[C_JUMP] = 1'b1; end
      OPC_BRANCH: begin ctrl[C_BRANCH] = 1'b1; alu_op = ALU_SUB; imm_sel = IMM_B; end
      OPC_LOAD:   begin ctrl[C_MUX2] = 1'b1; ctrl[C_MUX3] = 1'b1; ctrl[C_REG_WR] = 1'b1; ctrl[C_MEM_RD] = 1'b1; end
      OPC_STORE:  begin ctrl[C_MUX2] = 1'b1; ctrl[C_MEM_WR] = 1'b1; imm_sel = IMM_S; end
      OPC_OPIMM:  begin
        ctrl[C_MUX2] = 1'b1; ctrl[C_REG_WR] = 1'b1;
        // only shifts use instr[30] in the immediate form
        alu_op = alu_arith(funct3, alt && funct3 == 3'b101);
      end
      OPC_OP:     begin
        ctrl[C_REG_WR] = 1'b1;
        alu_op = mext ? {2'b10, funct3} : alu_arith(funct3, alt);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/immediate_extend.sv
// Builds the sign-extended immediate for the I/S/B/U/J formats.
module immediate_extend
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm
);
  logic signed [31:0] v;

  always_comb begin
    case (imm_sel)
      IMM_S:   v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   v = {instr[31:12], 12'b0};
      IMM_J:   v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: v = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  assign imm = XLEN'(v);
endmodule

// File: rtl/regfile_bypass.sv
// 2-read/1-write register file, x0 hardwired to zero, optional same-cycle
// write-to-read bypass.
module regfile_bypass #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter bit BYPASS_EN = 1'b1,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0][AW-1:0]   rs,
  output logic [1:0][XLEN-1:0] data,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data
);
  logic [REG_COUNT-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs <= '0;
    else if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign data[p] = (rs[p] == '0) ? '0 :
                     (BYPASS_EN && wb_en && wb_addr == rs[p]) ? wb_data : regs[rs[p]];
  end
endmodule

// File: rtl/id_stage_pipelined.sv
// Decode stage with its own ID/EX register: regfile read with WB bypass,
// load-use stall (one bubble), flush and per-slot valid.
module id_stage_pipelined
  import rv32_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter bit BYPASS_EN = 1'b1,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [XLEN-1:0]   if_pc4,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_pc4,
  output logic [XLEN-1:0]   ex_data1,
  output logic [XLEN-1:0]   ex_data2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_alu_op,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [AW-1:0]     ex_rs1,
  output logic [AW-1:0]     ex_rs2,
  output logic [AW-1:0]     ex_rd,
  output logic [2:0]        ex_funct3
);
  logic [6:0]            opc;
  logic [AW-1:0]         rs1, rs2, rd;
  logic [CTRL_W-1:0]     ctrl;
  logic [4:0]            alu_op;
  logic [2:0]            imm_sel;
  logic [XLEN-1:0]       imm;
  logic [1:0][XLEN-1:0]  rdata;
  logic                  uses_rs1, uses_rs2, load_use, kill;

  assign opc = if_instr[6:0];
  assign rs1 = AW'(if_instr[19:15]);
  assign rs2 = AW'(if_instr[24:20]);
  assign rd  = AW'(if_instr[11:7]);

  control_unit u_ctrl (
    .opcode(opc), .funct3(if_instr[14:12]), .alt(if_instr[30]), .mext(if_instr[25]),
    .ctrl(ctrl), .alu_op(alu_op), .imm_sel(imm_sel)
  );

  immediate_extend #(.XLEN(XLEN)) u_imm (
    .instr(if_instr[31:7]), .imm_sel(imm_sel), .imm(imm)
  );

  regfile_bypass #(.XLEN(XLEN), .REG_COUNT(REG_COUNT), .BYPASS_EN(BYPASS_EN)) u_rf (
    .clk(clk), .reset(reset), .rs({rs2, rs1}), .data(rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  assign uses_rs1 = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign uses_rs2 = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};

  // The bubble carries mem_rd=0, so the re-presented slot never stalls twice.
  assign load_use = if_valid && ex_valid && ex_ctrl[C_MEM_RD] && ex_rd != '0 &&
                    ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
  assign stall    = load_use && !flush;
  assign kill     = !if_valid || load_use || flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_pc     <= '0;
      ex_pc4    <= '0;
      ex_data1  <= '0;
      ex_data2  <= '0;
      ex_imm    <= '0;
      ex_alu_op <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct3 <= '0;
    end else begin
      ex_valid  <= !kill;
      ex_ctrl   <= kill ? '0 : ctrl;
      ex_pc     <= if_pc;
      ex_pc4    <= if_pc4;
      ex_data1  <= rdata[0];
      ex_data2  <= rdata[1];
      ex_imm    <= imm;
      ex_alu_op <= alu_op;
      ex_rs1    <= rs1;
      ex_rs2    <= rs2;
      ex_rd     <= rd;
      ex_funct3 <= if_instr[14:12];
    end
  end
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: vector table with a scoreboard queue, plus a
// hand-written mid-stream reset sequence. Runs bypass and no-bypass instances.
module tb_id_stage_pipelined;
  logic        clk = 1'b0, reset = 1'b0;
  logic        if_valid = 1'b0, flush = 1'b0, wb_en = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0, if_pc4 = '0, wb_data = '0;
  logic [4:0]  wb_addr = '0;

  logic        stall, ex_valid, nb_stall, nb_valid;
  logic [31:0] ex_pc, ex_pc4, ex_data1, ex_data2, ex_imm;
  logic [31:0] nb_pc, nb_pc4, nb_data1, nb_data2, nb_imm;
  logic [4:0]  ex_alu_op, ex_rs1, ex_rs2, ex_rd, nb_alu_op, nb_rs1, nb_rs2, nb_rd;
  logic [8:0]  ex_ctrl, nb_ctrl;
  logic [2:0]  ex_funct3, nb_funct3;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  id_stage_pipelined #(.XLEN(32), .REG_COUNT(32), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc4(if_pc4), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_data1(ex_data1),
    .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3)
  );

  id_stage_pipelined #(.XLEN(32), .REG_COUNT(32), .BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc4(if_pc4), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(nb_stall), .ex_valid(nb_valid), .ex_pc(nb_pc), .ex_pc4(nb_pc4), .ex_data1(nb_data1),
    .ex_data2(nb_data2), .ex_imm(nb_imm), .ex_alu_op(nb_alu_op), .ex_ctrl(nb_ctrl),
    .ex_rs1(nb_rs1), .ex_rs2(nb_rs2), .ex_rd(nb_rd), .ex_funct3(nb_funct3)
  );

  // chk bit0: datapath fields, bit1: immediate
  typedef struct {
    logic v; logic [31:0] instr, pc; logic fl, we; logic [4:0] wa; logic [31:0] wd;
    logic stall, valid; logic [8:0] ctrl; logic [1:0] chk;
    logic [31:0] d1, d1nb, d2, imm; logic [4:0] rs1, rd; logic [2:0] f3; logic [4:0] alu;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   sq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drain_one();
    vec_t e;
    int   i;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    i = sq.pop_front();
    chk($sformatf("valid[%0d]", i), ex_valid, e.valid);
    chk($sformatf("ctrl[%0d]", i), ex_ctrl, e.ctrl);
    if (e.chk[0]) begin
      chk($sformatf("data1[%0d]", i), ex_data1, e.d1);
      chk($sformatf("nb_data1[%0d]", i), nb_data1, e.d1nb);
      chk($sformatf("data2[%0d]", i), ex_data2, e.d2);
      chk($sformatf("rs1[%0d]", i), ex_rs1, e.rs1);
      chk($sformatf("rd[%0d]", i), ex_rd, e.rd);
      chk($sformatf("funct3[%0d]", i), ex_funct3, e.f3);
      chk($sformatf("alu[%0d]", i), ex_alu_op, e.alu);
      chk($sformatf("pc[%0d]", i), ex_pc, e.pc);
      chk($sformatf("pc4[%0d]", i), ex_pc4, e.pc + 32'd4);
    end
    if (e.chk[1]) chk($sformatf("imm[%0d]", i), ex_imm, e.imm);
  endtask

  task automatic apply(input vec_t r, input int i);
    @(negedge clk);
    drain_one();
    if_valid = r.v; if_instr = r.instr; if_pc = r.pc; if_pc4 = r.pc + 32'd4;
    flush = r.fl; wb_en = r.we; wb_addr = r.wa; wb_data = r.wd;
    #1 chk($sformatf("stall[%0d]", i), stall, r.stall);
    sb.push_back(r);
    sq.push_back(i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, ex_valid, 0);
    chk({tag, "_ctrl"}, ex_ctrl, 0);
    chk({tag, "_pc"}, ex_pc, 0);
    chk({tag, "_pc4"}, ex_pc4, 0);
    chk({tag, "_data1"}, ex_data1, 0);
    chk({tag, "_data2"}, ex_data2, 0);
    chk({tag, "_imm"}, ex_imm, 0);
    chk({tag, "_rs_rd"}, {ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_alu_op}, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    //           v instr          pc    fl we wa wd             st va ctrl   chk d1            d1nb          d2            imm           rs1 rd f3 alu
    tbl.push_back('{0, 32'h00000013, 32'h000, 0, 1, 1, 32'd3,        0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 32'h00000013, 32'h000, 0, 1, 2, 32'd3,        0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 32'h00000013, 32'h000, 0, 1, 5, 32'h11111111, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h00028333, 32'h100, 0, 1, 5, 32'hDEADBEEF, 0, 1, 9'h020, 1, 32'hDEADBEEF, 32'h11111111, 0, 0, 5, 6, 0, 0});
    tbl.push_back('{1, 32'h00500493, 32'h104, 0, 1, 0, 32'h1234,     0, 1, 9'h0A0, 3, 0, 0, 32'hDEADBEEF, 5, 0, 9, 0, 0});
    tbl.push_back('{1, 32'h00500493, 32'h108, 0, 0, 0, 0,            0, 1, 9'h0A0, 3, 0, 0, 32'hDEADBEEF, 5, 0, 9, 0, 0});
    tbl.push_back('{1, 32'h0000A383, 32'h10C, 0, 0, 0, 0,            0, 1, 9'h0E8, 3, 3, 3, 0, 0, 1, 7, 2, 0});
    tbl.push_back('{1, 32'h00238433, 32'h110, 0, 0, 0, 0,            1, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h00238433, 32'h110, 0, 0, 0, 0,            0, 1, 9'h020, 1, 0, 0, 3, 0, 7, 8, 0, 0});
    tbl.push_back('{1, 32'h0000A383, 32'h114, 0, 0, 0, 0,            0, 1, 9'h0E8, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h000383B7, 32'h118, 0, 0, 0, 0,            0, 1, 9'h0A0, 2, 0, 0, 0, 32'h00038000, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h0000A383, 32'h11C, 0, 0, 0, 0,            0, 1, 9'h0E8, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h00238433, 32'h120, 1, 0, 0, 0,            0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'hFE208CE3, 32'h200, 0, 0, 0, 0,            0, 1, 9'h004, 3, 3, 3, 3, 32'hFFFFFFF8, 1, 25, 0, 1});
    tbl.push_back('{1, 32'hFFFFFFFF, 32'h204, 0, 0, 0, 0,            0, 1, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h0000A383, 32'h300, 0, 0, 0, 0,            0, 1, 9'h0E8, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 32'h00238433, 32'h304, 0, 0, 0, 0,            0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h0000A003, 32'h308, 0, 0, 0, 0,            0, 1, 9'h0E8, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h00200433, 32'h30C, 0, 0, 0, 0,            0, 1, 9'h020, 1, 0, 0, 3, 0, 0, 8, 0, 0});
    tbl.push_back('{1, 32'h0000A383, 32'h310, 0, 0, 0, 0,            0, 1, 9'h0E8, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h0070A023, 32'h314, 0, 0, 0, 0,            1, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h0070A023, 32'h314, 0, 0, 0, 0,            0, 1, 9'h090, 3, 3, 3, 0, 0, 1, 0, 2, 0});
    tbl.push_back('{0, 32'h00000013, 32'h000, 0, 0, 0, 0,            0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    // reset state
    #1 chk_all_zero("reset");
    chk("reset_nb_valid", nb_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset_held");
    reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);
    @(negedge clk);
    drain_one();

    // reset asserted between edges while a load is in flight
    if_valid = 1'b1; if_instr = 32'h0000A383; if_pc = 32'h400; if_pc4 = 32'h404;
    flush = 1'b0; wb_en = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", ex_valid, 1);
    chk("pre_rst_ctrl", ex_ctrl, 9'h0E8);
    #2;
    reset = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55555555;
    if_instr = 32'h00238433;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    chk_all_zero("mid_rst_edge");
    reset = 1'b1; wb_en = 1'b0;
    if_instr = 32'h00028333; if_pc = 32'h500; if_pc4 = 32'h504;
    @(negedge clk);
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_x5", ex_data1, 0);
    chk("post_rst_x5_nb", nb_data1, 0);
    chk("post_rst_rs1", ex_rs1, 5);
    chk("post_rst_pc", ex_pc, 32'h500);
    if_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
